// File: rtl/control_pipeline_unit.sv
// Decode-stage control unit: decodes opcodeD and carries the control word through the E, M and WB stages.
// Vector writes wider than the lane count are issued as consecutive lane-group beats.
module control_pipeline_unit #(
    parameter int OPCODE_WIDTH  = 4,
    parameter int VECTOR_LENGTH = 8,
    parameter int LANES         = 4,
    localparam int NUM_BEATS    = (VECTOR_LENGTH + LANES - 1) / LANES,
    localparam int BEAT_W       = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OPCODE_WIDTH-1:0] opcodeD,
    input  logic                    validD,
    input  logic                    stallE,
    input  logic                    flushE,
    output logic                    readyD,
    output logic                    validE,
    output logic                    isScalarInstructionE,
    output logic                    isVectorScalarOperationE,
    output logic                    useInmediateE,
    output logic                    illegalOpcodeE,
    output logic [2:0]              aluControlE,
    output logic [BEAT_W-1:0]       beatE,
    output logic [LANES-1:0]        laneMaskE,
    output logic                    validM,
    output logic                    writeToMemoryEnableM,
    output logic                    outFlagM,
    output logic                    validW,
    output logic                    resultSelectorW,
    output logic                    writeEnableScalarW,
    output logic                    writeEnableVectorW
);

    typedef struct packed {
        logic       isScalar;
        logic       vsOp;
        logic       resultSel;
        logic       weScalar;
        logic       weVector;
        logic       weMem;
        logic       useImm;
        logic [2:0] alu;
        logic       outFlag;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {IDLE, ISSUE} state_t;

    function automatic ctrl_t decodeOp(input logic [OPCODE_WIDTH-1:0] op);
        ctrl_t c;
        c = '0;
        if ((op >> 4) != '0) begin
            c.illegal = 1'b1;
        end else begin
            case (op[3:0])
                4'h0: ;
                4'h1: begin c.isScalar = 1'b1; c.weMem = 1'b1; c.alu = 3'b110; end
                4'h2: begin c.isScalar = 1'b1; c.resultSel = 1'b1; c.weVector = 1'b1; c.alu = 3'b110; end
                4'h3: begin c.isScalar = 1'b1; c.weScalar = 1'b1; c.useImm = 1'b1; c.alu = 3'b111; end
                4'h4: begin c.isScalar = 1'b1; c.resultSel = 1'b1; c.outFlag = 1'b1; c.alu = 3'b110; end
                4'h5: begin c.isScalar = 1'b1; c.weScalar = 1'b1; c.alu = 3'b000; end
                4'h6: begin c.isScalar = 1'b1; c.weScalar = 1'b1; c.alu = 3'b001; end
                4'h7: begin c.weVector = 1'b1; c.alu = 3'b000; end
                4'h8: begin c.weVector = 1'b1; c.alu = 3'b001; end
                4'h9: begin c.weVector = 1'b1; c.alu = 3'b011; end
                4'hA: begin c.vsOp = 1'b1; c.weVector = 1'b1; c.useImm = 1'b1; c.alu = 3'b010; end
                4'hB: begin c.isScalar = 1'b1; c.alu = 3'b001; end
                4'hC, 4'hD, 4'hE: begin c.isScalar = 1'b1; c.useImm = 1'b1; c.alu = 3'b111; end
                default: c.illegal = 1'b1;
            endcase
        end
        return c;
    endfunction

    // Only the final beat can be partial: it covers the elements left over after the full groups.
    function automatic logic [LANES-1:0] beatMask(input logic [BEAT_W-1:0] beat);
        localparam int LAST_LANES = VECTOR_LENGTH - (NUM_BEATS - 1) * LANES;
        logic [LANES-1:0] m;
        m = '1;
        if (int'(beat) == NUM_BEATS - 1) begin
            for (int i = 0; i < LANES; i++) m[i] = (i < LAST_LANES);
        end
        return m;
    endfunction

    // Vector work lights every lane, scalar work lane 0, nop/illegal none.
    function automatic logic [LANES-1:0] singleMask(input ctrl_t c);
        logic [LANES-1:0] m;
        m = '0;
        if (c.weVector || c.vsOp) m = '1;
        else if (c.isScalar)      m[0] = 1'b1;
        return m;
    endfunction

    state_t                  state;
    logic [OPCODE_WIDTH-1:0] seqOpcode;
    logic [BEAT_W-1:0]       nextBeat;
    ctrl_t                   decD;
    ctrl_t                   seqCtrl;
    logic                    accept;
    logic                    multiBeatD;

    ctrl_t             ctrl_p0;
    logic              vld_p0;
    logic [BEAT_W-1:0] beat_p0;
    logic [LANES-1:0]  mask_p0;

    logic vld_p1, weMem_p1, outFlag_p1, resultSel_p1, weScalar_p1, weVector_p1;
    logic vld_p2, resultSel_p2, weScalar_p2, weVector_p2;

    assign decD       = decodeOp(opcodeD);
    assign seqCtrl    = decodeOp(seqOpcode);
    assign multiBeatD = decD.weVector && (NUM_BEATS > 1);
    assign readyD     = !rst && !stallE && (state == IDLE);
    assign accept     = validD && readyD;

    // E stage and beat sequencer
    always_ff @(posedge clk) begin
        if (rst || flushE) begin
            state    <= IDLE;
            nextBeat <= '0;
            vld_p0   <= 1'b0;
            ctrl_p0  <= '0;
            beat_p0  <= '0;
            mask_p0  <= '0;
            if (rst) seqOpcode <= '0;
        end else if (stallE) begin
            state <= state;
        end else if (state == ISSUE) begin
            vld_p0  <= 1'b1;
            ctrl_p0 <= seqCtrl;
            beat_p0 <= nextBeat;
            mask_p0 <= beatMask(nextBeat);
            if (int'(nextBeat) == NUM_BEATS - 1) begin
                state    <= IDLE;
                nextBeat <= '0;
            end else begin
                nextBeat <= nextBeat + 1'b1;
            end
        end else if (accept) begin
            vld_p0  <= 1'b1;
            ctrl_p0 <= decD;
            beat_p0 <= '0;
            if (multiBeatD) begin
                mask_p0   <= beatMask('0);
                state     <= ISSUE;
                nextBeat  <= BEAT_W'(1);
                seqOpcode <= opcodeD;
            end else begin
                mask_p0 <= singleMask(decD);
            end
        end else begin
            vld_p0  <= 1'b0;
            ctrl_p0 <= '0;
            beat_p0 <= '0;
            mask_p0 <= '0;
        end
    end

    // M stage
    always_ff @(posedge clk) begin
        if (rst || stallE) begin
            vld_p1       <= 1'b0;
            weMem_p1     <= 1'b0;
            outFlag_p1   <= 1'b0;
            resultSel_p1 <= 1'b0;
            weScalar_p1  <= 1'b0;
            weVector_p1  <= 1'b0;
        end else begin
            vld_p1       <= vld_p0;
            weMem_p1     <= ctrl_p0.weMem;
            outFlag_p1   <= ctrl_p0.outFlag;
            resultSel_p1 <= ctrl_p0.resultSel;
            weScalar_p1  <= ctrl_p0.weScalar;
            weVector_p1  <= ctrl_p0.weVector;
        end
    end

    // WB stage
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2       <= 1'b0;
            resultSel_p2 <= 1'b0;
            weScalar_p2  <= 1'b0;
            weVector_p2  <= 1'b0;
        end else begin
            vld_p2       <= vld_p1;
            resultSel_p2 <= resultSel_p1;
            weScalar_p2  <= weScalar_p1;
            weVector_p2  <= weVector_p1;
        end
    end

    assign validE                   = vld_p0;
    assign isScalarInstructionE     = ctrl_p0.isScalar;
    assign isVectorScalarOperationE = ctrl_p0.vsOp;
    assign useInmediateE            = ctrl_p0.useImm;
    assign illegalOpcodeE           = ctrl_p0.illegal;
    assign aluControlE              = ctrl_p0.alu;
    assign beatE                    = beat_p0;
    assign laneMaskE                = mask_p0;
    assign validM                   = vld_p1;
    assign writeToMemoryEnableM     = weMem_p1;
    assign outFlagM                 = outFlag_p1;
    assign validW                   = vld_p2;
    assign resultSelectorW          = resultSel_p2;
    assign writeEnableScalarW       = weScalar_p2;
    assign writeEnableVectorW       = weVector_p2;

endmodule

// File: tb/tb_control_pipeline_unit.sv
// Directed bench for control_pipeline_unit: opcode table sweep plus multi-beat, stall, flush and reset sequences.
module tb_control_pipeline_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, validD, stallE, flushE;
    logic [3:0] opcodeD;
    logic       readyD, validE, isScalarInstructionE, isVectorScalarOperationE, useInmediateE, illegalOpcodeE;
    logic [2:0] aluControlE;
    logic [0:0] beatE;
    logic [3:0] laneMaskE;
    logic       validM, writeToMemoryEnableM, outFlagM;
    logic       validW, resultSelectorW, writeEnableScalarW, writeEnableVectorW;

    logic       validD10;
    logic [3:0] opcodeD10;
    logic       readyD10, validE10, isScalarE10, vsE10, immE10, illegalE10;
    logic [2:0] aluE10;
    logic [1:0] beatE10;
    logic [3:0] laneMaskE10;
    logic       validM10, wmM10, ofM10, validW10, rsW10, wesW10, wevW10;

    control_pipeline_unit #(.OPCODE_WIDTH(4), .VECTOR_LENGTH(8), .LANES(4)) dut (
        .clk(clk), .rst(rst), .opcodeD(opcodeD), .validD(validD), .stallE(stallE), .flushE(flushE),
        .readyD(readyD), .validE(validE), .isScalarInstructionE(isScalarInstructionE),
        .isVectorScalarOperationE(isVectorScalarOperationE), .useInmediateE(useInmediateE),
        .illegalOpcodeE(illegalOpcodeE), .aluControlE(aluControlE), .beatE(beatE), .laneMaskE(laneMaskE),
        .validM(validM), .writeToMemoryEnableM(writeToMemoryEnableM), .outFlagM(outFlagM),
        .validW(validW), .resultSelectorW(resultSelectorW), .writeEnableScalarW(writeEnableScalarW),
        .writeEnableVectorW(writeEnableVectorW)
    );

    control_pipeline_unit #(.OPCODE_WIDTH(4), .VECTOR_LENGTH(10), .LANES(4)) dut10 (
        .clk(clk), .rst(rst), .opcodeD(opcodeD10), .validD(validD10), .stallE(1'b0), .flushE(1'b0),
        .readyD(readyD10), .validE(validE10), .isScalarInstructionE(isScalarE10),
        .isVectorScalarOperationE(vsE10), .useInmediateE(immE10),
        .illegalOpcodeE(illegalE10), .aluControlE(aluE10), .beatE(beatE10), .laneMaskE(laneMaskE10),
        .validM(validM10), .writeToMemoryEnableM(wmM10), .outFlagM(ofM10),
        .validW(validW10), .resultSelectorW(rsW10), .writeEnableScalarW(wesW10),
        .writeEnableVectorW(wevW10)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] ctrlE();
        return {isScalarInstructionE, isVectorScalarOperationE, useInmediateE, illegalOpcodeE, aluControlE};
    endfunction

    function automatic logic [19:0] allOuts();
        return {validE, ctrlE(), beatE, laneMaskE, validM, writeToMemoryEnableM, outFlagM,
                validW, resultSelectorW, writeEnableScalarW, writeEnableVectorW};
    endfunction

    // ctrl = {S, VS, IMM, ILL, ALU}; mctl = {WM, OF}; wctl = {RS, WES, WEV}
    typedef struct {
        logic [3:0] op;
        logic [6:0] ctrl;
        logic [3:0] mask;
        logic [1:0] mctl;
        logic [2:0] wctl;
        logic       multi;
        logic       chkMask;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] tOps[7];
        logic [2:0] tAlu[7];
        logic [3:0] masks10[3];

        vecs[0]  = '{4'h0, 7'b0000_000, 4'b0000, 2'b00, 3'b000, 1'b0, 1'b0};
        vecs[1]  = '{4'h1, 7'b1000_110, 4'b0001, 2'b10, 3'b000, 1'b0, 1'b1};
        vecs[2]  = '{4'h2, 7'b1000_110, 4'b1111, 2'b00, 3'b101, 1'b1, 1'b1};
        vecs[3]  = '{4'h3, 7'b1010_111, 4'b0001, 2'b00, 3'b010, 1'b0, 1'b1};
        vecs[4]  = '{4'h4, 7'b1000_110, 4'b0001, 2'b01, 3'b100, 1'b0, 1'b1};
        vecs[5]  = '{4'h5, 7'b1000_000, 4'b0001, 2'b00, 3'b010, 1'b0, 1'b1};
        vecs[6]  = '{4'h6, 7'b1000_001, 4'b0001, 2'b00, 3'b010, 1'b0, 1'b1};
        vecs[7]  = '{4'h7, 7'b0000_000, 4'b1111, 2'b00, 3'b001, 1'b1, 1'b1};
        vecs[8]  = '{4'h8, 7'b0000_001, 4'b1111, 2'b00, 3'b001, 1'b1, 1'b1};
        vecs[9]  = '{4'h9, 7'b0000_011, 4'b1111, 2'b00, 3'b001, 1'b1, 1'b1};
        vecs[10] = '{4'hA, 7'b0110_010, 4'b1111, 2'b00, 3'b001, 1'b1, 1'b1};
        vecs[11] = '{4'hB, 7'b1000_001, 4'b0001, 2'b00, 3'b000, 1'b0, 1'b1};
        vecs[12] = '{4'hC, 7'b1010_111, 4'b0001, 2'b00, 3'b000, 1'b0, 1'b1};
        vecs[13] = '{4'hD, 7'b1010_111, 4'b0001, 2'b00, 3'b000, 1'b0, 1'b1};
        vecs[14] = '{4'hE, 7'b1010_111, 4'b0001, 2'b00, 3'b000, 1'b0, 1'b1};
        vecs[15] = '{4'hF, 7'b0001_000, 4'b0000, 2'b00, 3'b000, 1'b0, 1'b0};
        tOps    = '{4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'hB, 4'hC};
        tAlu    = '{3'b110, 3'b111, 3'b110, 3'b000, 3'b001, 3'b001, 3'b111};
        masks10 = '{4'b1111, 4'b1111, 4'b0011};

        rst = 1'b1; validD = 1'b0; opcodeD = 4'h0; stallE = 1'b0; flushE = 1'b0;
        validD10 = 1'b0; opcodeD10 = 4'h0;

        // reset state
        tick(); tick();
        chk("reset.outs", allOuts(), 20'h0);
        chk("reset.readyD", readyD, 1'b0);
        rst = 1'b0;
        #1 chk("reset.readyAfter", readyD, 1'b1);

        // opcode table sweep
        for (int i = 0; i < 16; i++) begin
            opcodeD = vecs[i].op; validD = 1'b1;
            #1 chk($sformatf("op%h.readyD", vecs[i].op), readyD, 1'b1);
            tick();
            validD = 1'b0; opcodeD = 4'h0;
            chk($sformatf("op%h.E", vecs[i].op), {validE, ctrlE(), beatE}, {1'b1, vecs[i].ctrl, 1'b0});
            if (vecs[i].chkMask) chk($sformatf("op%h.mask", vecs[i].op), laneMaskE, vecs[i].mask);
            tick();
            chk($sformatf("op%h.M", vecs[i].op), {validM, writeToMemoryEnableM, outFlagM}, {1'b1, vecs[i].mctl});
            if (vecs[i].multi)
                chk($sformatf("op%h.beat1", vecs[i].op), {validE, ctrlE(), beatE, laneMaskE},
                    {1'b1, vecs[i].ctrl, 1'b1, 4'b1111});
            else
                chk($sformatf("op%h.Eidle", vecs[i].op), validE, 1'b0);
            tick();
            chk($sformatf("op%h.W", vecs[i].op),
                {validW, resultSelectorW, writeEnableScalarW, writeEnableVectorW}, {1'b1, vecs[i].wctl});
            tick();
        end

        // back-to-back single-beat throughput
        for (int i = 0; i < 7; i++) begin
            opcodeD = tOps[i]; validD = 1'b1;
            #1 chk("thru.readyD", readyD, 1'b1);
            tick();
            chk($sformatf("thru%0d.E", i), {validE, aluControlE}, {1'b1, tAlu[i]});
            if (i > 0) chk($sformatf("thru%0d.M", i), validM, 1'b1);
        end
        validD = 1'b0;
        tick(); tick(); tick();

        // 0111 then 0101
        opcodeD = 4'h7; validD = 1'b1;
        #1 chk("seq75.ready0", readyD, 1'b1);
        tick();
        opcodeD = 4'h5;
        chk("seq75.beat0", {validE, beatE, laneMaskE}, {1'b1, 1'b0, 4'b1111});
        #1 chk("seq75.readyLow", readyD, 1'b0);
        tick();
        chk("seq75.beat1", {validE, beatE, laneMaskE, aluControlE}, {1'b1, 1'b1, 4'b1111, 3'b000});
        #1 chk("seq75.readyBack", readyD, 1'b1);
        tick();
        validD = 1'b0;
        chk("seq75.op5", {validE, ctrlE(), beatE, laneMaskE}, {1'b1, 7'b1000_000, 1'b0, 4'b0001});
        tick(); tick(); tick();

        // VECTOR_LENGTH=10: three beats of 1010
        opcodeD10 = 4'hA; validD10 = 1'b1;
        #1 chk("vl10.ready", readyD10, 1'b1);
        tick();
        validD10 = 1'b0;
        for (int b = 0; b < 3; b++) begin
            chk($sformatf("vl10.beat%0d", b), {validE10, vsE10, immE10, aluE10, beatE10, laneMaskE10},
                {1'b1, 1'b1, 1'b1, 3'b010, 2'(b), masks10[b]});
            if (b < 2) chk($sformatf("vl10.readyLow%0d", b), readyD10, 1'b0);
            tick();
        end
        chk("vl10.done", {validE10, readyD10}, 2'b01);
        tick(); tick();

        // stall two cycles on beat 1 of 1000
        opcodeD = 4'h8; validD = 1'b1;
        #1 tick();
        validD = 1'b0;
        chk("stall.beat0", {validE, beatE}, 2'b10);
        tick();
        chk("stall.beat1", {validE, beatE, validM}, 3'b111);
        stallE = 1'b1;
        #1 chk("stall.readyLow", readyD, 1'b0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk($sformatf("stall.hold%0d", c), {validE, beatE, aluControlE, validM}, {1'b1, 1'b1, 3'b001, 1'b0});
        end
        stallE = 1'b0;
        tick();
        chk("stall.release", {validE, validM}, 2'b01);
        tick();
        chk("stall.noDup", validM, 1'b0);
        tick(); tick();

        // flush together with stall during beat 0 of 0111
        opcodeD = 4'h7; validD = 1'b1;
        #1 tick();
        validD = 1'b0;
        flushE = 1'b1; stallE = 1'b1;
        #1 chk("flush.readyLow", readyD, 1'b0);
        tick();
        chk("flush.bubble", {validE, beatE, laneMaskE, validM}, 7'b0);
        flushE = 1'b0; stallE = 1'b0;
        opcodeD = 4'h3; validD = 1'b1;
        #1 chk("flush.readyIdle", readyD, 1'b1);
        tick();
        validD = 1'b0;
        chk("flush.next", {validE, ctrlE(), laneMaskE}, {1'b1, 7'b1010_111, 4'b0001});
        tick();
        chk("flush.noBeat1", validE, 1'b0);
        tick(); tick();

        // reset in the middle of a multi-beat issue
        opcodeD = 4'h8; validD = 1'b1;
        #1 tick();
        validD = 1'b0;
        rst = 1'b1;
        #1 chk("rstMid.readyLow", readyD, 1'b0);
        tick();
        chk("rstMid.outs", allOuts(), 20'h0);
        chk("rstMid.readyHeld", readyD, 1'b0);
        rst = 1'b0;
        opcodeD = 4'h1; validD = 1'b1;
        #1 chk("rstMid.readyAfter", readyD, 1'b1);
        tick();
        validD = 1'b0;
        chk("rstMid.E", {validE, beatE}, 2'b10);
        tick();
        chk("rstMid.M", {validM, writeToMemoryEnableM}, 2'b11);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
